// File: rtl/io_queue_pkg.sv
// Shared constants for the pin-limited push/pop storage tile.
// Pin map of the 8-in/8-out harness and the ordering-mode codes.
package io_queue_pkg;

    localparam int MODE_FIFO = 0;
    localparam int MODE_LIFO = 1;

    localparam int DATA_W = 4;

    localparam int PIN_CLK     = 0;
    localparam int PIN_RST     = 1;
    localparam int PIN_PUSH    = 2;
    localparam int PIN_POP     = 3;
    localparam int PIN_DIN_LSB = 4;

    localparam int PIN_HEAD_LSB = 0;
    localparam int PIN_EMPTY    = 4;
    localparam int PIN_FULL     = 5;
    localparam int PIN_OVF      = 6;
    localparam int PIN_UDF      = 7;

endpackage

// File: rtl/io_queue_if.sv
// Tile harness pin bundle: eight inputs in, eight outputs out.
// The clock and reset travel on io_i like every other pin.
interface io_queue_if;

    logic [7:0] io_i;
    logic [7:0] io_o;

    modport master (
        output io_i,
        input  io_o
    );

    modport slave (
        input  io_i,
        output io_o
    );

endinterface

// File: rtl/io_queue_edge_rise.sv
// One-bit rising-edge detector with a configurable reset level.
// Resetting to 1 suppresses an event for a level held through reset.
module io_edge_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Remember last cycle's level to find the low-to-high transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/io_queue_top.sv
// Edge-triggered FIFO/LIFO buffer of 4-bit values on the tile pins.
// State updates on the event edge; pins follow one clock later.
module io_queue_top
    import io_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int MODE  = MODE_FIFO
) (
    io_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic              clk;
    logic              rst;
    logic              push_lvl;
    logic              pop_lvl;
    logic [DATA_W-1:0] din;

    logic              push_evt;
    logic              pop_evt;
    logic              do_push;
    logic              do_pop;
    logic              full_s;
    logic              empty_s;

    logic [CW-1:0]     count_q;
    logic              ovf_q;
    logic              udf_q;
    logic [DATA_W-1:0] head_s;
    logic [7:0]        out_q;

    assign clk      = bus.io_i[PIN_CLK];
    assign rst      = bus.io_i[PIN_RST];
    assign push_lvl = bus.io_i[PIN_PUSH];
    assign pop_lvl  = bus.io_i[PIN_POP];
    assign din      = bus.io_i[PIN_DIN_LSB +: DATA_W];

    io_edge_rise #(
        .RST_VAL (1'b1)
    ) u_push_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (push_lvl),
        .rise (push_evt)
    );

    io_edge_rise #(
        .RST_VAL (1'b1)
    ) u_pop_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (pop_lvl),
        .rise (pop_evt)
    );

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == '0);

    // A push while full only lands when a pop frees the slot in the same
    // event; a pop needs something to remove.
    assign do_push = push_evt & (~full_s | pop_evt);
    assign do_pop  = pop_evt & ~empty_s;

    // Occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
            if (push_evt && !pop_evt && full_s) begin
                ovf_q <= 1'b1;
            end
            if (pop_evt && !push_evt && empty_s) begin
                udf_q <= 1'b1;
            end
        end
    end

    generate
        if (MODE == MODE_LIFO) begin : g_lifo

            logic [DATA_W-1:0] mem [DEPTH];
            logic [PW-1:0]     top_q;
            logic [PW-1:0]     wr_idx;

            // Push with pop replaces the top entry in place.
            assign wr_idx = (do_push && do_pop) ? top_q - 1'b1 : top_q;
            assign head_s = mem[top_q - 1'b1];

            // Top pointer moves only for a lone push or a lone pop.
            always_ff @(posedge clk) begin
                if (rst) begin
                    top_q <= '0;
                end else if (do_push && !do_pop) begin
                    top_q <= top_q + 1'b1;
                end else if (do_pop && !do_push) begin
                    top_q <= top_q - 1'b1;
                end
            end

            // Storage holds no reset value; writes are blocked during reset.
            always_ff @(posedge clk) begin
                if (!rst && do_push) begin
                    mem[wr_idx] <= din;
                end
            end

        end else begin : g_fifo

            logic [DATA_W-1:0] mem [DEPTH];
            logic [PW-1:0]     wr_ptr_q;
            logic [PW-1:0]     rd_ptr_q;

            assign head_s = mem[rd_ptr_q];

            // Independent write and read pointers wrapping modulo DEPTH.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (do_push) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                    if (do_pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                end
            end

            // Storage holds no reset value; writes are blocked during reset.
            always_ff @(posedge clk) begin
                if (!rst && do_push) begin
                    mem[wr_ptr_q] <= din;
                end
            end

        end
    endgenerate

    // Register every pin from state so io_o never sees io_i directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 8'h10;
        end else begin
            out_q[PIN_UDF]   <= udf_q;
            out_q[PIN_OVF]   <= ovf_q;
            out_q[PIN_FULL]  <= full_s;
            out_q[PIN_EMPTY] <= empty_s;
            out_q[PIN_HEAD_LSB +: DATA_W] <= empty_s ? '0 : head_s;
        end
    end

    assign bus.io_o = out_q;

endmodule

// File: tb/tb_io_queue_top.sv
// Bench for io_queue_top: FIFO and LIFO instances share the stimulus,
// directed table rows, hand sequences, then random ops against queues.
module tb_io_queue_top;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic [3:0] din;

    int nvec;
    int nerr;

    io_queue_if f_if ();
    io_queue_if l_if ();

    assign f_if.io_i = {din, pop, push, rst, clk};
    assign l_if.io_i = {din, pop, push, rst, clk};

    io_queue_top #(.DEPTH(DEPTH), .MODE(0)) u_fifo (.bus(f_if));
    io_queue_top #(.DEPTH(DEPTH), .MODE(1)) u_lifo (.bus(l_if));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain queues and sticky bits.
    logic [3:0] q_f[$];
    logic [3:0] q_l[$];
    bit ovf_f, udf_f, ovf_l, udf_l;

    task automatic model_clear();
        q_f.delete();
        q_l.delete();
        ovf_f = 0; udf_f = 0; ovf_l = 0; udf_l = 0;
    endtask

    task automatic model_op(bit p, bit o, logic [3:0] d);
        if (p && o) begin
            if (q_f.size() == 0) q_f.push_back(d);
            else begin
                void'(q_f.pop_front());
                q_f.push_back(d);
            end
            if (q_l.size() == 0) q_l.push_back(d);
            else q_l[q_l.size()-1] = d;
        end else if (p) begin
            if (q_f.size() == DEPTH) ovf_f = 1;
            else q_f.push_back(d);
            if (q_l.size() == DEPTH) ovf_l = 1;
            else q_l.push_back(d);
        end else if (o) begin
            if (q_f.size() == 0) udf_f = 1;
            else void'(q_f.pop_front());
            if (q_l.size() == 0) udf_l = 1;
            else void'(q_l.pop_back());
        end
    endtask

    function automatic logic [7:0] exp_f();
        logic [3:0] h;
        h = (q_f.size() == 0) ? 4'h0 : q_f[0];
        return {udf_f, ovf_f, q_f.size() == DEPTH, q_f.size() == 0, h};
    endfunction

    function automatic logic [7:0] exp_l();
        logic [3:0] h;
        h = (q_l.size() == 0) ? 4'h0 : q_l[q_l.size()-1];
        return {udf_l, ovf_l, q_l.size() == DEPTH, q_l.size() == 0, h};
    endfunction

    task automatic chk(string name, logic [7:0] ef, logic [7:0] el);
        nvec++;
        if (f_if.io_o !== ef) begin
            nerr++;
            $display("FAIL %s fifo io_o=%h expected=%h", name, f_if.io_o, ef);
        end
        nvec++;
        if (l_if.io_o !== el) begin
            nerr++;
            $display("FAIL %s lifo io_o=%h expected=%h", name, l_if.io_o, el);
        end
    endtask

    task automatic do_reset();
        push = 0; pop = 0; rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        model_clear();
        chk("reset", 8'h10, 8'h10);
    endtask

    task automatic op(bit p, bit o, logic [3:0] d, int hold);
        push = p; pop = o; din = d;
        repeat (hold) @(negedge clk);
        push = 0; pop = 0;
        @(negedge clk);
        model_op(p, o, d);
    endtask

    typedef struct {
        bit         p;
        bit         o;
        logic [3:0] d;
        logic [7:0] ef;
        logic [7:0] el;
    } vec_t;

    vec_t tbl[11];

    initial begin
        nvec = 0; nerr = 0;
        rst = 1; push = 1; pop = 0; din = 4'h0;
        model_clear();

        tbl[0]  = '{1, 0, 4'h3, 8'h03, 8'h03};
        tbl[1]  = '{1, 0, 4'h7, 8'h03, 8'h07};
        tbl[2]  = '{1, 0, 4'hA, 8'h03, 8'h0A};
        tbl[3]  = '{0, 1, 4'h0, 8'h07, 8'h07};
        tbl[4]  = '{1, 1, 4'h6, 8'h0A, 8'h06};
        tbl[5]  = '{0, 1, 4'h0, 8'h06, 8'h03};
        tbl[6]  = '{0, 1, 4'h0, 8'h10, 8'h10};
        tbl[7]  = '{0, 1, 4'h0, 8'h90, 8'h90};
        tbl[8]  = '{1, 0, 4'h5, 8'h85, 8'h85};
        tbl[9]  = '{0, 1, 4'h0, 8'h90, 8'h90};
        tbl[10] = '{1, 1, 4'h9, 8'h89, 8'h89};

        // Push held high through reset and after release: no event.
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("held_push_no_fire", 8'h10, 8'h10);
        push = 0;
        @(negedge clk);
        op(1, 0, 4'h4, 1);
        chk("push_after_release", 8'h04, 8'h04);

        // One clock of output latency after the event edge.
        do_reset();
        push = 1; din = 4'h2;
        @(negedge clk);
        chk("latency_old", 8'h10, 8'h10);
        push = 0;
        @(negedge clk);
        model_op(1, 0, 4'h2);
        chk("latency_new", 8'h02, 8'h02);

        // Held request yields a single event.
        op(1, 0, 4'hB, 3);
        chk("held_one_event", exp_f(), exp_l());

        do_reset();
        for (int i = 0; i < 11; i++) begin
            op(tbl[i].p, tbl[i].o, tbl[i].d, 1);
            chk($sformatf("table_%0d", i), tbl[i].ef, tbl[i].el);
        end

        // Fill, overflow, drain.
        do_reset();
        for (int i = 0; i < DEPTH; i++) op(1, 0, 4'(i), 1);
        chk("fill_full", 8'h20, 8'h27);
        op(1, 0, 4'hF, 1);
        chk("overflow", 8'h60, 8'h67);
        for (int i = 0; i < DEPTH; i++) begin
            op(0, 1, 4'h0, 1);
            chk($sformatf("drain_%0d", i), exp_f(), exp_l());
        end
        chk("drained", 8'h50, 8'h50);

        // Push and pop together while full.
        do_reset();
        for (int i = 0; i < DEPTH; i++) op(1, 0, 4'(i), 1);
        op(1, 1, 4'hC, 1);
        chk("full_push_pop", 8'h21, 8'h2C);

        // Reset issued mid-sequence with a push edge in the same cycle.
        push = 0;
        @(negedge clk);
        push = 1; rst = 1; din = 4'hD;
        repeat (2) @(negedge clk);
        push = 0; rst = 0;
        @(negedge clk);
        model_clear();
        chk("reset_priority", 8'h10, 8'h10);

        // Randomised operations.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(39) == 0) begin
                do_reset();
            end else begin
                op(1'($urandom), 1'($urandom), 4'($urandom),
                   int'($urandom_range(3, 1)));
                chk($sformatf("rand_%0d", n), exp_f(), exp_l());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/io_queue_top.md
# io_queue_top

Pin-limited storage project for the 8-in/8-out tile harness, wrapped by the same `io_i`/`io_o` top-level contract the bench drives. It captures 4-bit values from switch inputs into a `DEPTH`-entry buffer and plays them back on the output pins. A parameter selects queue (FIFO) or stack (LIFO) order. Push and pop are edge-triggered and status is shown on dedicated pins, so the block is usable with slow, manually toggled inputs.

## Interface
- `DEPTH`, 8: number of entries; power of two, 2..16.
- `MODE`, 0: 0 = FIFO (oldest entry at head), 1 = LIFO (newest entry at head).
- `io_i[0]`  input  1  clock; the tile clock, and the only clock.
- `io_i[1]`  input  1  reset; synchronous, active-high.
- `io_i[2]`  input  1  push request (level; a rising edge is one push).
- `io_i[3]`  input  1  pop request (level; a rising edge is one pop).
- `io_i[7:4]`  input  4  push data.
- `io_o[3:0]`  output  4  head entry; 0 when empty.
- `io_o[4]`  output  1  empty.
- `io_o[5]`  output  1  full (count == `DEPTH`).
- `io_o[6]`  output  1  overflow, sticky.
- `io_o[7]`  output  1  underflow, sticky.

## Operation
- **Edge detect**
  - Registers `push_q` and `pop_q` sample `io_i[2]` and `io_i[3]` every clock.
  - `push_evt = io_i[2] & ~push_q`; `pop_evt = io_i[3] & ~pop_q`.
  - Reset sets `push_q` and `pop_q` to 1, so a request held through reset does not fire. It fires only after it is released and raised again.
- **State**
  - Storage array, write pointer, read pointer, and count. Count width is `$clog2(DEPTH)+1`.
  - Pointers wrap modulo `DEPTH`.
- **FIFO (`MODE`=0)**
  - Push only, not full: write `io_i[7:4]` at the write pointer, increment the write pointer, count+1.
  - Pop only, not empty: increment the read pointer, count-1.
  - Push and pop together, not empty: both actions happen; count is unchanged. This includes the full case.
  - Push and pop together, empty: push only; no underflow.
- **LIFO (`MODE`=1)**
  - A single top pointer is used. Push writes at top and then increments it; pop decrements it.
  - Push and pop together, not empty: the top entry is overwritten in place; count is unchanged.
  - Push and pop together, empty: push only.
- **Error cases**
  - Push only while full: data is dropped, state is unchanged, and overflow is set.
  - Pop only while empty: state is unchanged and underflow is set.
  - Overflow and underflow clear only on reset.
- **Outputs**
  - All outputs are driven from registers; there is no combinational path from `io_i` to `io_o`.
  - Head is the read-pointer entry for FIFO and the top-1 entry for LIFO. It is registered together with the flags.
- **Reset**
  - Pointers, count, and flags go to 0. Storage contents are don't-care.
  - `io_o` = 8'b0001_0000.
  - Reset takes priority over any push or pop in the same cycle, including mid-sequence.

## Timing
- Inputs are sampled on the clock rising edge.
- A push or pop edge present at edge N updates state at edge N.
- `io_o` reflects the new state after edge N+1, i.e. 1 cycle of output latency. This holds for empty, full, the error flags, and the head value.
- A request held high produces exactly one event. A new event needs at least one clock with the input low.
- Back-to-back events need at least 2 clocks per push or pop.
- A full sequence of `DEPTH` pushes followed by `DEPTH` pops returns count to 0 with no flags set.

## Structure
- **Package `io_queue_pkg`**
  - `MODE_FIFO`=0 and `MODE_LIFO`=1.
  - Pin index constants: `PIN_CLK`, `PIN_RST`, `PIN_PUSH`, `PIN_POP`, `PIN_DIN_LSB`, `PIN_EMPTY`, `PIN_FULL`, `PIN_OVF`, `PIN_UDF`.
- **Sub-module `io_edge_rise`**
  - One-bit rising-edge detector with a settable reset value.
  - Instantiated twice, for push and pop.
- Storage and pointer logic stay in the top; `MODE` selects between them with a generate.

## Test plan
- **Reset:** apply reset for 2 clocks with push held high, then release while push stays high.
  - Required: `io_o` = 8'h10, and no push occurs until push falls and rises again.
- **FIFO order:** push 3, 7, 'hA, then pop once.
  - Required: head reads 3 after the pushes and 7 after the pop; empty=0, full=0.
- **LIFO order (`MODE`=1):** push 3, 7, 'hA, then pop once.
  - Required: head reads 'hA after the pushes and 7 after the pop.
- **Fill and overflow (`DEPTH`=8):** push 0..7, then push 'hF.
  - Required: full=1, overflow=1, count stays 8; popping 8 times yields 0..7 and then empty=1. Overflow remains 1 until reset.
- **Underflow:** pop while empty.
  - Required: underflow=1 and head=0; a following push of 5 works with head=5. Underflow stays 1.
- **Simultaneous push and pop:**
  - Empty FIFO, push+pop with 9: head=9, count 1, no underflow.
  - Full FIFO, push+pop: count stays 8, no overflow.
  - LIFO top of 4, push+pop with 6: head=6, count unchanged.
